uart_dbg_bridge: RTL

- Host-side debug bridge sitting on the initiator side of the UART data register interface (reg_dat_we/re/di/do/wait).
- Pulls command bytes from the UART, decodes a fixed binary protocol and issues single-word reads/writes as a native-memory bus master (mem_valid/mem_ready).
- Returns responses through the UART TX path, giving an external host peek/poke access to the SoC bus without the CPU.

---
 rtl/uart_dbg_pkg.sv | 21 ++
 rtl/uart_dbg_byteio.sv | 52 +++++
 rtl/uart_dbg_bridge.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared types and protocol constants for the UART debug bridge.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_BUS,
    ST_TX_RESP
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'hAA;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_dbg_byteio.sv
// Byte-level handshake with the UART data register: one-cycle read strobe
// after each taken byte, write enable held with stable data until accepted.
module uart_dbg_byteio (
  input  logic        clk,
  input  logic        resetn,
  output logic        uart_dat_we,
  output logic        uart_dat_re,
  output logic [31:0] uart_dat_di,
  input  logic [31:0] uart_dat_do,
  input  logic        uart_dat_wait,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  input  logic        rx_take,
  input  logic        tx_req,
  input  logic [7:0]  tx_byte,
  output logic        tx_done
);

  logic       re_q;
  logic       we_q;
  logic [7:0] di_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      re_q <= 1'b0;
      we_q <= 1'b0;
      di_q <= 8'h00;
    end else begin
      re_q <= rx_take && rx_valid;
      if (we_q) begin
        if (!uart_dat_wait) we_q <= 1'b0;
      end else if (tx_req) begin
        we_q <= 1'b1;
        di_q <= tx_byte;
      end
    end
  end

  // Masking with re_q gives the UART one cycle to clear its valid flag.
  assign rx_valid    = !uart_dat_do[31] && !re_q && !we_q;
  assign rx_byte     = uart_dat_do[7:0];
  assign tx_done     = we_q && !uart_dat_wait;
  assign uart_dat_we = we_q;
  assign uart_dat_re = re_q;
  assign uart_dat_di = {24'h0, di_q};

  logic unused_do_bits;
  assign unused_do_bits = ^uart_dat_do[30:8];

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-driven debug bus master: host peek/poke over a binary byte protocol.
// Optional inter-byte timeout when UART_DBG_TIMEOUT_EN is defined.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        uart_dat_we,
  output logic        uart_dat_re,
  output logic [31:0] uart_dat_di,
  input  logic [31:0] uart_dat_do,
  input  logic        uart_dat_wait,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q;
  logic        is_write_q;
  logic        rsp_one_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_q;

  logic        rx_valid, rx_take, tx_req, tx_done, timeout;
  logic [7:0]  rx_byte;

  uart_dbg_byteio u_byteio (
    .clk           (clk),
    .resetn        (resetn),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_re   (uart_dat_re),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_do   (uart_dat_do),
    .uart_dat_wait (uart_dat_wait),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .rx_take       (rx_take),
    .tx_req        (tx_req),
    .tx_byte       (rsp_q[7:0]),
    .tx_done       (tx_done)
  );

`ifdef UART_DBG_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        in_rx;
  assign in_rx = (state_q == ST_RX_ADDR) || (state_q == ST_RX_DATA);

  always_ff @(posedge clk) begin
    if (!resetn || rx_take || !in_rx) tmo_q <= 32'h0;
    else                              tmo_q <= tmo_q + 32'h1;
  end

  assign timeout = in_rx && (tmo_q == 32'(TIMEOUT_CYCLES));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rx_take = 1'b0;
    tx_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          rx_take = 1'b1;
          state_d = is_cmd(rx_byte) ? ST_RX_ADDR : ST_TX_RESP;
        end
      end
      ST_RX_ADDR: begin
        if (rx_valid) begin
          rx_take = 1'b1;
          if (cnt_q == 2'd3) state_d = is_write_q ? ST_RX_DATA : ST_BUS;
        end
      end
      ST_RX_DATA: begin
        if (rx_valid) begin
          rx_take = 1'b1;
          if (cnt_q == 2'd3) state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ready) state_d = ST_TX_RESP;
      end
      ST_TX_RESP: begin
        tx_req = 1'b1;
        if (tx_done && (rsp_one_q || cnt_q == 2'd3)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled host abandons the partial command without any response.
    if (timeout) begin
      rx_take = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // NOTE: the datapath is a handful of flops, not a memory array, so all of
  // it takes the synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= 2'd0;
      is_write_q <= 1'b0;
      rsp_one_q  <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rsp_q      <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= 2'd0;
          if (rx_take) begin
            is_write_q <= (rx_byte == CMD_WRITE);
            if (!is_cmd(rx_byte)) begin
              rsp_q     <= {24'h0, RSP_ERR};
              rsp_one_q <= 1'b1;
            end
          end
        end
        ST_RX_ADDR: if (rx_take) begin
          addr_q <= {rx_byte, addr_q[31:8]};
          cnt_q  <= cnt_q + 2'd1;
        end
        ST_RX_DATA: if (rx_take) begin
          wdata_q <= {rx_byte, wdata_q[31:8]};
          cnt_q   <= cnt_q + 2'd1;
        end
        ST_BUS: if (mem_ready) begin
          rsp_q     <= is_write_q ? {24'h0, RSP_ACK} : mem_rdata;
          rsp_one_q <= is_write_q;
        end
        ST_TX_RESP: if (tx_done) begin
          rsp_q <= {8'h00, rsp_q[31:8]};
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state_q == ST_BUS);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = is_write_q ? 4'hF : 4'h0;
  assign busy      = (state_q != ST_IDLE);

  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_q[1:0];

endmodule
